// File: rtl/game_round_timer.sv
// Round timer: button edge detect, run/pause/over FSM, speed-scaled frame prescaler, second countdown.
// All outputs registered; frame/second/done are single-cycle strobes.
module game_round_timer #(
  parameter int cycles_per_frame_p  = 16,
  parameter int frames_per_second_p = 8,
  parameter int round_seconds_p     = 4,
  parameter int width_p             = 32,
  localparam int SW = $clog2(round_seconds_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               startbutton_i,
  input  logic               pausebutton_i,
  input  logic [1:0]         speed_i,
  output logic [width_p-1:0] fstep_o,
  output logic               frame_o,
  output logic               second_o,
  output logic [SW-1:0]      seconds_left_o,
  output logic [1:0]         state_o,
  output logic               done_o
);

  localparam int PW = $clog2(cycles_per_frame_p + 1);
  localparam int FW = $clog2(frames_per_second_p + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t        state;
  logic          start_q;
  logic          pause_q;
  logic [PW-1:0] presc;
  logic [PW-1:0] div_q;
  logic [FW-1:0] fcnt;

  wire start_ev = startbutton_i & ~start_q;
  wire pause_ev = pausebutton_i & ~pause_q;

  function automatic logic [PW-1:0] calc_div(input logic [1:0] spd);
    logic [PW-1:0] d;
    d = PW'(cycles_per_frame_p >> spd);
    if (d == '0) d = PW'(1);
    return d;
  endfunction

  assign state_o = state;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      pause_q        <= 1'b0;
      presc          <= '0;
      div_q          <= PW'(cycles_per_frame_p);
      fcnt           <= '0;
      fstep_o        <= '0;
      frame_o        <= 1'b0;
      second_o       <= 1'b0;
      done_o         <= 1'b0;
      seconds_left_o <= SW'(round_seconds_p);
    end else begin
      start_q  <= startbutton_i;
      pause_q  <= pausebutton_i;
      frame_o  <= 1'b0;
      second_o <= 1'b0;
      done_o   <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start_ev) begin
            state          <= RUN;
            fstep_o        <= '0;
            presc          <= '0;
            fcnt           <= '0;
            seconds_left_o <= SW'(round_seconds_p);
            div_q          <= calc_div(speed_i);
          end
        end
        RUN: begin
          if (pause_ev) state <= PAUSE;
          // >= rather than == keeps the wrap safe even if div_q ever shrinks below the count
          if (presc >= div_q - PW'(1)) begin
            presc   <= '0;
            div_q   <= calc_div(speed_i);
            fstep_o <= fstep_o + width_p'(1);
            frame_o <= 1'b1;
            if (fcnt == FW'(frames_per_second_p - 1)) begin
              fcnt           <= '0;
              second_o       <= 1'b1;
              seconds_left_o <= seconds_left_o - SW'(1);
              if (seconds_left_o == SW'(1)) begin
                state  <= OVER;
                done_o <= 1'b1;
              end
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        PAUSE: begin
          if (pause_ev) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_timer.sv
// Scoreboard bench for game_round_timer at default parameters.
module tb_game_round_timer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        startbutton = 1'b0;
  logic        pausebutton = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic [31:0] fstep_o;
  logic        frame_o;
  logic        second_o;
  logic [2:0]  seconds_left_o;
  logic [1:0]  state_o;
  logic        done_o;

  always #5 clk = ~clk;

  game_round_timer #(
    .cycles_per_frame_p(16),
    .frames_per_second_p(8),
    .round_seconds_p(4),
    .width_p(32)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .startbutton_i(startbutton),
    .pausebutton_i(pausebutton),
    .speed_i(speed),
    .fstep_o(fstep_o),
    .frame_o(frame_o),
    .second_o(second_o),
    .seconds_left_o(seconds_left_o),
    .state_o(state_o),
    .done_o(done_o)
  );

  typedef struct {
    int   cyc;
    int   fstep;
    logic sec;
    int   left;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_round(output int t0);
    startbutton = 1'b1;
    tick();
    t0 = cyc;
    startbutton = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({state_o, seconds_left_o, fstep_o, frame_o, second_o, done_o} !== {2'd0, 3'd4, 32'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_hold got state=%0d left=%0d fstep=%0d strobes=%b want 0 4 0 000",
               state_o, seconds_left_o, fstep_o, {frame_o, second_o, done_o});
    end
    reset_i = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      checks++;
      if ({state_o, seconds_left_o, fstep_o, frame_o, second_o, done_o} !== {2'd0, 3'd4, 32'd0, 3'b000}) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got state=%0d left=%0d fstep=%0d strobes=%b want 0 4 0 000",
                 i, state_o, seconds_left_o, fstep_o, {frame_o, second_o, done_o});
      end
    end
  endtask

  task automatic test_full_round(input logic [1:0] spd, input int div);
    int   t0;
    exp_t e;
    speed = spd;
    for (int n = 1; n <= 32; n++)
      exp_q.push_back('{cyc: n * div, fstep: n, sec: (n % 8 == 0), left: 4 - n / 8, done: (n == 32)});
    start_round(t0);
    for (int i = 0; i < 32 * div + 20; i++) begin
      tick();
      if (frame_o || second_o || done_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL round_spd%0d extra strobe at %0d", spd, cyc - t0);
        end else begin
          e = exp_q.pop_front();
          if ((cyc - t0) !== e.cyc ||
              {frame_o, second_o, done_o, fstep_o, seconds_left_o, state_o} !==
              {1'b1, e.sec, e.done, 32'(e.fstep), 3'(e.left), (e.done ? 2'd3 : 2'd1)}) begin
            errors++;
            $display("FAIL round_spd%0d got cyc=%0d fstep=%0d f/s/d=%b left=%0d state=%0d want cyc=%0d fstep=%0d f/s/d=%b left=%0d",
                     spd, cyc - t0, fstep_o, {frame_o, second_o, done_o}, seconds_left_o, state_o,
                     e.cyc, e.fstep, {1'b1, e.sec, e.done}, e.left);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || {state_o, fstep_o, seconds_left_o} !== {2'd3, 32'd32, 3'd0}) begin
      errors++;
      $display("FAIL round_spd%0d_end pending=%0d state=%0d fstep=%0d left=%0d want 0 3 32 0",
               spd, exp_q.size(), state_o, fstep_o, seconds_left_o);
    end
    exp_q.delete();
  endtask

  task automatic test_restart_reset();
    pausebutton = 1'b1;
    tick();
    pausebutton = 1'b0;
    checks++;
    if ({state_o, fstep_o, seconds_left_o} !== {2'd3, 32'd32, 3'd0}) begin
      errors++;
      $display("FAIL over_pause got state=%0d fstep=%0d left=%0d want 3 32 0", state_o, fstep_o, seconds_left_o);
    end
    startbutton = 1'b1;
    tick();
    startbutton = 1'b0;
    checks++;
    if ({state_o, fstep_o, seconds_left_o} !== {2'd1, 32'd0, 3'd4}) begin
      errors++;
      $display("FAIL restart got state=%0d fstep=%0d left=%0d want 1 0 4", state_o, fstep_o, seconds_left_o);
    end
    repeat (40) tick();
    #2 reset_i = 1'b0;
    #1;
    checks++;
    if ({state_o, fstep_o, seconds_left_o, frame_o, second_o, done_o} !== {2'd0, 32'd0, 3'd4, 3'b000}) begin
      errors++;
      $display("FAIL async_reset got state=%0d fstep=%0d left=%0d want 0 0 4", state_o, fstep_o, seconds_left_o);
    end
    reset_i = 1'b1;
    repeat (20) tick();
    checks++;
    if ({state_o, fstep_o} !== {2'd0, 32'd0}) begin
      errors++;
      $display("FAIL post_reset_idle got state=%0d fstep=%0d want 0 0", state_o, fstep_o);
    end
  endtask

  task automatic test_pause();
    int   t0;
    int   c;
    exp_t e;
    speed = 2'd0;
    for (int n = 1; n <= 32; n++)
      exp_q.push_back('{cyc: (n <= 6) ? 16 * n : 16 * n + 50, fstep: n, sec: (n % 8 == 0),
                        left: 4 - n / 8, done: (n == 32)});
    start_round(t0);
    for (int i = 0; i < 600; i++) begin
      tick();
      c = cyc - t0;
      pausebutton = (c == 99 || c == 149);
      if (c >= 100 && c <= 150) begin
        checks++;
        if (fstep_o !== 32'd6 || {frame_o, second_o, done_o} !== 3'b000 ||
            state_o !== ((c == 150) ? 2'd1 : 2'd2)) begin
          errors++;
          $display("FAIL paused at %0d got fstep=%0d strobes=%b state=%0d want 6 000 %0d",
                   c, fstep_o, {frame_o, second_o, done_o}, state_o, (c == 150) ? 1 : 2);
        end
      end
      if (frame_o || second_o || done_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pause_round extra strobe at %0d", c);
        end else begin
          e = exp_q.pop_front();
          if (c !== e.cyc || {frame_o, second_o, done_o, fstep_o, seconds_left_o} !==
              {1'b1, e.sec, e.done, 32'(e.fstep), 3'(e.left)}) begin
            errors++;
            $display("FAIL pause_round got cyc=%0d fstep=%0d f/s/d=%b left=%0d want cyc=%0d fstep=%0d f/s/d=%b left=%0d",
                     c, fstep_o, {frame_o, second_o, done_o}, seconds_left_o,
                     e.cyc, e.fstep, {1'b1, e.sec, e.done}, e.left);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || state_o !== 2'd3) begin
      errors++;
      $display("FAIL pause_round_end pending=%0d state=%0d want 0 3", exp_q.size(), state_o);
    end
    exp_q.delete();
  endtask

  task automatic test_speed_switch();
    int   t0;
    int   c;
    exp_t e;
    speed = 2'd0;
    exp_q.push_back('{cyc: 16, fstep: 1, sec: 1'b0, left: 4, done: 1'b0});
    exp_q.push_back('{cyc: 32, fstep: 2, sec: 1'b0, left: 4, done: 1'b0});
    exp_q.push_back('{cyc: 34, fstep: 3, sec: 1'b0, left: 4, done: 1'b0});
    exp_q.push_back('{cyc: 36, fstep: 4, sec: 1'b0, left: 4, done: 1'b0});
    exp_q.push_back('{cyc: 38, fstep: 5, sec: 1'b0, left: 4, done: 1'b0});
    start_round(t0);
    for (int i = 0; i < 39; i++) begin
      tick();
      c = cyc - t0;
      if (c == 16) speed = 2'd3;
      if (frame_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL speed_switch extra frame at %0d", c);
        end else begin
          e = exp_q.pop_front();
          if (c !== e.cyc || fstep_o !== 32'(e.fstep)) begin
            errors++;
            $display("FAIL speed_switch got cyc=%0d fstep=%0d want cyc=%0d fstep=%0d", c, fstep_o, e.cyc, e.fstep);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL speed_switch missing %0d frames", exp_q.size());
    end
    exp_q.delete();
    speed = 2'd0;
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous();
    startbutton = 1'b1;
    pausebutton = 1'b1;
    tick();
    checks++;
    if (state_o !== 2'd1) begin
      errors++;
      $display("FAIL both_in_idle got state=%0d want 1", state_o);
    end
    startbutton = 1'b0;
    pausebutton = 1'b0;
    repeat (3) tick();
    startbutton = 1'b1;
    pausebutton = 1'b1;
    tick();
    checks++;
    if (state_o !== 2'd2) begin
      errors++;
      $display("FAIL both_in_run got state=%0d want 2", state_o);
    end
    startbutton = 1'b0;
    pausebutton = 1'b0;
    tick();
    startbutton = 1'b1;
    tick();
    startbutton = 1'b0;
    tick();
    checks++;
    if ({state_o, fstep_o, seconds_left_o} !== {2'd2, 32'd0, 3'd4}) begin
      errors++;
      $display("FAIL start_in_pause got state=%0d fstep=%0d left=%0d want 2 0 4", state_o, fstep_o, seconds_left_o);
    end
    pausebutton = 1'b1;
    tick();
    pausebutton = 1'b0;
    checks++;
    if (state_o !== 2'd1) begin
      errors++;
      $display("FAIL resume got state=%0d want 1", state_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_round(2'd0, 16);
    test_full_round(2'd2, 4);
    test_restart_reset();
    test_pause();
    test_speed_switch();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_round_timer.md
# game_round_timer

Parametrised game-timing controller for the Game_dev top level. It replaces the fixed start-button/frame-step state machine with a configurable round timer: run, pause and game-over modes, a run-time speed select, and a countdown of remaining round seconds. It sits between the board buttons and the game logic, supplying the frame-step count, one-cycle frame and second strobes, and round status.

## Interface
- cycles_per_frame_p, 16: clock cycles per frame at speed 0; must be ≥ 1.
- frames_per_second_p, 8: frames per game second; must be ≥ 1.
- round_seconds_p, 4: seconds per round; must be ≥ 1.
- width_p, 32: width of fstep_o.
- clk_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- startbutton_i  in  1  start request, already synchronous to clk_i; acts on its rising edge.
- pausebutton_i  in  1  pause/resume toggle, already synchronous; acts on its rising edge.
- speed_i  in  2  speed select; frame divider = max(1, cycles_per_frame_p >> speed_i).
- fstep_o  out  width_p  frames elapsed in the current round.
- frame_o  out  1  one-cycle strobe per frame.
- second_o  out  1  one-cycle strobe per game second.
- seconds_left_o  out  $clog2(round_seconds_p+1)  seconds remaining in the round.
- state_o  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.
- done_o  out  1  one-cycle strobe on entry to OVER.

## Operation
- Edge detect: one register per button holds the previous sample. An event is the current input at 1 with the previous sample at 0. The registers reset to 0.
- IDLE: start event → RUN.
- OVER: start event → RUN.
- Entry to RUN from IDLE or OVER: fstep_o, prescaler and frame-in-second counter clear to 0; seconds_left_o loads round_seconds_p.
- RUN, prescaler: counts every cycle. When the count is ≥ div−1 it wraps to 0 and a frame occurs.
- RUN, speed sampling: div is computed from speed_i at RUN entry and at each wrap only. Using ≥ gives a safe wrap when div shrinks.
- RUN, frame: fstep_o increments, wrapping modulo 2^width_p; frame_o=1; the frame-in-second counter increments.
- RUN, second: on the frames_per_second_p-th frame, the frame-in-second counter clears, second_o=1 and seconds_left_o decrements.
- RUN, round end: when seconds_left_o reaches 0, the state goes to OVER with done_o=1, all in the same cycle as that second_o.
- RUN: pause event → PAUSE.
- PAUSE: prescaler, counters and outputs are frozen; no strobes. A pause event → RUN resumes from the frozen prescaler value. Start events are ignored.
- OVER: fstep_o and seconds_left_o (=0) hold. Pause events are ignored.
- Simultaneous events: in RUN/PAUSE, pause wins and start is ignored. In IDLE/OVER, start wins.
- Reset mid-operation: all state returns to reset values immediately (asynchronous assert); the run resumes only via a new start event.

## Timing
- Reset values: state_o=0, fstep_o=0, frame_o=0, second_o=0, done_o=0, seconds_left_o=round_seconds_p. Prescaler and counters are 0.
- All outputs are registered; strobes are high for exactly one cycle.
- Button latency: an event sampled at edge k changes state_o after edge k.
- First frame_o comes div cycles after the RUN-entry edge. Frames follow every div cycles.
- second_o comes every frames_per_second_p·div cycles.
- OVER is reached round_seconds_p·frames_per_second_p·div cycles after RUN entry, excluding paused cycles.
- Pause latency: a pause event at edge k suppresses any frame that would fall on edge k+1 or later. Each resume adds exactly the paused cycle count.

## Test plan
Defaults apply throughout: cycles_per_frame_p=16, frames_per_second_p=8, round_seconds_p=4.
- Reset check: hold reset_i=0, then release → state_o=0, seconds_left_o=4, fstep_o=0, no strobes for 1000 cycles without a start event.
- Full round at speed_i=0 after a start pulse: frame_o every 16 cycles; second_o every 128 cycles, with seconds_left_o 3,2,1,0; done_o and state_o=3 at cycle 512; fstep_o=32 and held.
- Full round at speed_i=2 (div 4): second_o every 32 cycles; OVER at cycle 128 with fstep_o=32. Switching speed_i 0→3 mid-round changes the frame spacing to 2 cycles after the next wrap.
- Pause: pause at cycle 100 of RUN for 50 cycles, then resume → fstep_o holds 6 while paused; OVER lands at cycle 562; no strobes during PAUSE.
- Simultaneous events: start and pause edges together in IDLE → RUN. Both together in RUN → PAUSE. Start in PAUSE → ignored.
- Restart and reset: start in OVER → fstep_o=0, seconds_left_o=4, new round. reset_i low mid-RUN → immediate reset values.
